// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access
//  Purpose  : Memory-access stage of the RV32I pipeline. It latches the
//             executed instruction and performs byte, halfword and word
//             loads and stores over a data-memory bus that allows one
//             request in flight at a time. Load data is sign- or
//             zero-extended. The stage result feeds writeback and the
//             M-forwarding path.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ACK_TIMEOUT   cycles spent in REQ without DMEM_ACK before the access
//                  is aborted (1..65535)
//  Ports
//    CLK, RST                 clock, synchronous active-low reset
//    STALL, FLUSH             stage-latch hold / bubble insert (STALL wins)
//    A_PC, A_INST, A_VALID    executed instruction bundle from execute
//    A_REG_D, A_REG_D_V       destination register and ALU result / address
//    A_STORE_DATA             forwarded rs2 value for stores
//    DMEM_REQ/WE/ADDR/STRB/WDATA   data-memory request (held until done)
//    DMEM_ACK, DMEM_RDATA     one-cycle completion pulse and read data
//    M_BUSY                   access in flight (OR-ed into STALL upstream)
//    M_PC, M_INST, M_VALID    latched instruction; valid only when idle
//    M_REG_D, M_REG_D_V       writeback destination and value
//    M_MISALIGN, M_BUS_ERR    fault flags for the latched instruction
// ============================================================================
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [31:0] A_PC,
    input  logic [31:0] A_INST,
    input  logic        A_VALID,
    input  logic [4:0]  A_REG_D,
    input  logic [31:0] A_REG_D_V,
    input  logic [31:0] A_STORE_DATA,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [3:0]  DMEM_STRB,
    output logic [31:0] DMEM_WDATA,
    input  logic        DMEM_ACK,
    input  logic [31:0] DMEM_RDATA,
    output logic        M_BUSY,
    output logic [31:0] M_PC,
    output logic [31:0] M_INST,
    output logic        M_VALID,
    output logic [4:0]  M_REG_D,
    output logic [31:0] M_REG_D_V,
    output logic        M_MISALIGN,
    output logic        M_BUS_ERR
);

    localparam logic [6:0]  OP_LOAD      = 7'b0000011;
    localparam logic [6:0]  OP_STORE     = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH    = 7'b1100011;
    // Counter value seen in the last permitted REQ cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // funct3[1:0] encodes access size: 00 byte, 01 halfword, 1x word.
    function automatic logic is_aligned(input logic [1:0] size,
                                        input logic [1:0] addr);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~addr[0];
            default: return (addr == 2'b00);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stage latch and FSM state
    // ------------------------------------------------------------------
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] alu_q;
    logic [31:0] sdata_q;
    logic [31:0] rdata_q;
    logic [4:0]  rd_q;
    logic        valid_q;

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic        bus_err;
    logic        bus_err_next;
    logic        rdata_load;

    logic        busy;
    logic        capture;
    logic        in_mem_ok;

    assign busy    = (state == ST_REQ);
    // The stage also holds itself while busy, so a hazard unit that is
    // late to reflect M_BUSY into STALL cannot overwrite an in-flight op.
    assign capture = !STALL && !busy;

    // Incoming bundle is a well-formed memory op that needs the bus.
    assign in_mem_ok = A_VALID
                    && ((A_INST[6:0] == OP_LOAD) || (A_INST[6:0] == OP_STORE))
                    && is_aligned(A_INST[13:12], A_REG_D_V[1:0]);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc_q    <= 32'h0;
            inst_q  <= 32'h0;
            alu_q   <= 32'h0;
            sdata_q <= 32'h0;
            rd_q    <= 5'h0;
            valid_q <= 1'b0;
        end else if (capture) begin
            if (FLUSH) begin
                pc_q    <= 32'h0;
                inst_q  <= 32'h0;
                alu_q   <= 32'h0;
                sdata_q <= 32'h0;
                rd_q    <= 5'h0;
                valid_q <= 1'b0;
            end else begin
                pc_q    <= A_PC;
                inst_q  <= A_INST;
                alu_q   <= A_REG_D_V;
                sdata_q <= A_STORE_DATA;
                rd_q    <= A_REG_D;
                valid_q <= A_VALID;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= ST_IDLE;
            cnt     <= 16'h0;
            bus_err <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bus_err <= bus_err_next;
            if (rdata_load) begin
                rdata_q <= DMEM_RDATA;
            end
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bus_err_next = bus_err;
        rdata_load   = 1'b0;
        case (state)
            ST_REQ: begin
                // ACK takes priority over a timeout landing on the same edge.
                if (DMEM_ACK) begin
                    state_next = ST_DONE;
                    rdata_load = 1'b1;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next   = ST_DONE;
                    bus_err_next = 1'b1;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            default: begin
                // IDLE and DONE ignore ACK; they only move on a capture edge.
                if (capture) begin
                    cnt_next     = 16'h0;
                    bus_err_next = 1'b0;
                    state_next   = (!FLUSH && in_mem_ok) ? ST_REQ : ST_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------
    logic [6:0]  op_q;
    logic [2:0]  f3_q;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        misalign;

    assign op_q      = inst_q[6:0];
    assign f3_q      = inst_q[14:12];
    assign is_load   = (op_q == OP_LOAD);
    assign is_store  = (op_q == OP_STORE);
    assign is_branch = (op_q == OP_BRANCH);
    assign misalign  = valid_q && (is_load || is_store)
                    && !is_aligned(f3_q[1:0], alu_q[1:0]);

    // Load lane selection and extension.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    always_comb begin
        ld_byte  = 8'h00;
        ld_half  = 16'h0000;
        load_val = rdata_q;
        case (alu_q[1:0])
            2'b00:   ld_byte = rdata_q[7:0];
            2'b01:   ld_byte = rdata_q[15:8];
            2'b10:   ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'h0, ld_byte};
            3'b101:  load_val = {16'h0, ld_half};
            default: load_val = rdata_q;
        endcase
    end

    // Store byte enables and lane-replicated write data.
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;

    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = sdata_q;
        case (f3_q[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << alu_q[1:0];
                st_wdata = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                st_strb  = alu_q[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{sdata_q[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = sdata_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Bus fields are zero outside REQ so reset leaves every output 0.
        DMEM_REQ   = busy;
        DMEM_WE    = busy && is_store;
        DMEM_ADDR  = busy ? {alu_q[31:2], 2'b00} : 32'h0;
        DMEM_STRB  = busy ? (is_store ? st_strb : 4'b1111) : 4'b0000;
        DMEM_WDATA = (busy && is_store) ? st_wdata : 32'h0;

        M_BUSY     = busy;
        M_PC       = pc_q;
        M_INST     = inst_q;
        M_VALID    = valid_q && !busy;
        M_MISALIGN = misalign;
        M_BUS_ERR  = bus_err;

        // Faulted accesses, stores and branches never write a register.
        if (is_store || is_branch || misalign || bus_err) begin
            M_REG_D = 5'h0;
        end else begin
            M_REG_D = rd_q;
        end

        if (misalign || bus_err) begin
            M_REG_D_V = 32'h0;
        end else if (is_load) begin
            M_REG_D_V = load_val;
        end else begin
            M_REG_D_V = alu_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access
//  Purpose  : Scoreboard bench for mem_access. The driver pushes expected
//             stage results and bus transactions; independent monitors pop
//             and compare whenever the DUT presents them. A responder model
//             answers the data-memory bus with per-transaction ACK delays.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] v;
        logic        mis;
        logic        err;
    } out_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        we;
        bit          chk_wd;
        int          len;
    } bus_t;

    typedef struct {
        int          delay;   // ACK in this REQ cycle; 0 = never
        logic [31:0] rdata;
        bit          late;    // pulse ACK in the cycle after REQ drops
    } resp_t;

    logic        CLK;
    logic        RST;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] A_PC;
    logic [31:0] A_INST;
    logic        A_VALID;
    logic [4:0]  A_REG_D;
    logic [31:0] A_REG_D_V;
    logic [31:0] A_STORE_DATA;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [31:0] DMEM_ADDR;
    logic [3:0]  DMEM_STRB;
    logic [31:0] DMEM_WDATA;
    logic        DMEM_ACK;
    logic [31:0] DMEM_RDATA;
    logic        M_BUSY;
    logic [31:0] M_PC;
    logic [31:0] M_INST;
    logic        M_VALID;
    logic [4:0]  M_REG_D;
    logic [31:0] M_REG_D_V;
    logic        M_MISALIGN;
    logic        M_BUS_ERR;

    int tests = 0;
    int fails = 0;

    out_t  exp_q[$];
    bus_t  bus_q[$];
    resp_t resp_q[$];

    mem_access #(.ACK_TIMEOUT(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .STALL       (STALL),
        .FLUSH       (FLUSH),
        .A_PC        (A_PC),
        .A_INST      (A_INST),
        .A_VALID     (A_VALID),
        .A_REG_D     (A_REG_D),
        .A_REG_D_V   (A_REG_D_V),
        .A_STORE_DATA(A_STORE_DATA),
        .DMEM_REQ    (DMEM_REQ),
        .DMEM_WE     (DMEM_WE),
        .DMEM_ADDR   (DMEM_ADDR),
        .DMEM_STRB   (DMEM_STRB),
        .DMEM_WDATA  (DMEM_WDATA),
        .DMEM_ACK    (DMEM_ACK),
        .DMEM_RDATA  (DMEM_RDATA),
        .M_BUSY      (M_BUSY),
        .M_PC        (M_PC),
        .M_INST      (M_INST),
        .M_VALID     (M_VALID),
        .M_REG_D     (M_REG_D),
        .M_REG_D_V   (M_REG_D_V),
        .M_MISALIGN  (M_MISALIGN),
        .M_BUS_ERR   (M_BUS_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {17'h0, f3, rd, op};
    endfunction

    function automatic out_t mk_out(input logic [31:0] pc, input logic [31:0] inst,
                                    input logic [4:0] rd, input logic [31:0] v,
                                    input logic mis, input logic err);
        out_t o;
        o.pc = pc; o.inst = inst; o.rd = rd; o.v = v; o.mis = mis; o.err = err;
        return o;
    endfunction

    function automatic bus_t mk_bus(input logic [31:0] addr, input logic [3:0] strb,
                                    input logic [31:0] wd, input logic we,
                                    input bit chk, input int len);
        bus_t b;
        b.addr = addr; b.strb = strb; b.wdata = wd; b.we = we; b.chk_wd = chk; b.len = len;
        return b;
    endfunction

    function automatic resp_t mk_resp(input int delay, input logic [31:0] rdata,
                                      input bit late);
        resp_t r;
        r.delay = delay; r.rdata = rdata; r.late = late;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Memory responder
    // ------------------------------------------------------------------
    resp_t cur;
    bit    r_active = 1'b0;
    int    r_n      = 0;

    initial begin
        DMEM_ACK   = 1'b0;
        DMEM_RDATA = 32'h0;
        cur        = mk_resp(0, 32'h0, 1'b0);
        forever begin
            @(negedge CLK);
            DMEM_ACK = 1'b0;
            if (DMEM_REQ) begin
                if (!r_active) begin
                    r_active = 1'b1;
                    r_n      = 0;
                    cur      = (resp_q.size() > 0) ? resp_q.pop_front()
                                                   : mk_resp(0, 32'h0, 1'b0);
                end
                r_n++;
                if (cur.delay == r_n) begin
                    DMEM_ACK   = 1'b1;
                    DMEM_RDATA = cur.rdata;
                end
            end else if (r_active) begin
                r_active = 1'b0;
                if (cur.late) begin
                    DMEM_ACK   = 1'b1;
                    DMEM_RDATA = 32'h5555_5555;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result monitor: a result is consumed when valid and not stalled.
    // ------------------------------------------------------------------
    out_t e;

    initial begin
        forever begin
            @(negedge CLK);
            #1;
            if (M_VALID && !STALL) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got pc=%h rd=%0d v=%h, required no output",
                             M_PC, M_REG_D, M_REG_D_V);
                end else begin
                    e = exp_q.pop_front();
                    if (M_PC !== e.pc || M_INST !== e.inst || M_REG_D !== e.rd ||
                        M_REG_D_V !== e.v || M_MISALIGN !== e.mis || M_BUS_ERR !== e.err) begin
                        fails++;
                        $display("FAIL result pc=%h: got inst=%h rd=%0d v=%h mis=%b err=%b, required inst=%h rd=%0d v=%h mis=%b err=%b",
                                 e.pc, M_INST, M_REG_D, M_REG_D_V, M_MISALIGN, M_BUS_ERR,
                                 e.inst, e.rd, e.v, e.mis, e.err);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus monitor: checks request fields on the first REQ cycle and the
    // number of cycles REQ stays high.
    // ------------------------------------------------------------------
    bus_t b;
    bit   in_req = 1'b0;
    int   req_len = 0;

    initial begin
        b = mk_bus(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, -1);
        forever begin
            @(negedge CLK);
            #1;
            if (DMEM_REQ) begin
                if (!in_req) begin
                    in_req  = 1'b1;
                    req_len = 1;
                    tests++;
                    if (bus_q.size() == 0) begin
                        fails++;
                        b = mk_bus(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, -1);
                        $display("FAIL unexpected_req: got addr=%h we=%b, required no request",
                                 DMEM_ADDR, DMEM_WE);
                    end else begin
                        b = bus_q.pop_front();
                        if (DMEM_ADDR !== b.addr || DMEM_STRB !== b.strb || DMEM_WE !== b.we ||
                            (b.chk_wd && DMEM_WDATA !== b.wdata)) begin
                            fails++;
                            $display("FAIL bus_req: got addr=%h strb=%b we=%b wdata=%h, required addr=%h strb=%b we=%b wdata=%h",
                                     DMEM_ADDR, DMEM_STRB, DMEM_WE, DMEM_WDATA,
                                     b.addr, b.strb, b.we, b.wdata);
                        end
                    end
                end else begin
                    req_len++;
                end
            end else if (in_req) begin
                in_req = 1'b0;
                if (b.len >= 0) begin
                    tests++;
                    if (req_len != b.len) begin
                        fails++;
                        $display("FAIL req_len addr=%h: got %0d cycles, required %0d",
                                 b.addr, req_len, b.len);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic check_zero(input string name);
        tests++;
        if (DMEM_REQ !== 1'b0 || DMEM_WE !== 1'b0 || DMEM_ADDR !== 32'h0 ||
            DMEM_STRB !== 4'h0 || DMEM_WDATA !== 32'h0 || M_BUSY !== 1'b0 ||
            M_PC !== 32'h0 || M_INST !== 32'h0 || M_VALID !== 1'b0 ||
            M_REG_D !== 5'h0 || M_REG_D_V !== 32'h0 || M_MISALIGN !== 1'b0 ||
            M_BUS_ERR !== 1'b0) begin
            fails++;
            $display("FAIL %s: got req=%b busy=%b valid=%b pc=%h rd=%0d v=%h addr=%h, required all zero",
                     name, DMEM_REQ, M_BUSY, M_VALID, M_PC, M_REG_D, M_REG_D_V, DMEM_ADDR);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (M_BUSY && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        if (M_BUSY) begin
            tests++;
            fails++;
            $display("FAIL busy_bound: got M_BUSY=1 after %0d cycles, required 0", guard);
        end
    endtask

    // Called at a negedge; the following posedge is the capture edge.
    task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] sd, input logic valid, input logic flush,
                         input bit has_out, input out_t eo,
                         input bit has_bus, input bus_t eb, input resp_t rs);
        wait_idle();
        A_PC         = pc;
        A_INST       = inst;
        A_REG_D      = rd;
        A_REG_D_V    = alu;
        A_STORE_DATA = sd;
        A_VALID      = valid;
        FLUSH        = flush;
        if (has_out) exp_q.push_back(eo);
        if (has_bus) begin
            bus_q.push_back(eb);
            resp_q.push_back(rs);
        end
        @(negedge CLK);
    endtask

    task automatic alu_op(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [4:0] rd, input logic [31:0] v,
                          input logic [4:0] exp_rd);
        issue(pc, inst, rd, v, 32'h0, 1'b1, 1'b0, 1'b1,
              mk_out(pc, inst, exp_rd, v, 1'b0, 1'b0),
              1'b0, mk_bus(0, 0, 0, 0, 0, -1), mk_resp(0, 0, 0));
    endtask

    task automatic load_op(input logic [31:0] pc, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] addr,
                           input int delay, input logic [31:0] rdata,
                           input logic [31:0] exp_v);
        logic [31:0] inst;
        inst = mk(OP_LOAD, f3, rd);
        issue(pc, inst, rd, addr, 32'h0, 1'b1, 1'b0, 1'b1,
              mk_out(pc, inst, rd, exp_v, 1'b0, 1'b0),
              1'b1, mk_bus({addr[31:2], 2'b00}, 4'b1111, 32'h0, 1'b0, 1'b0, delay),
              mk_resp(delay, rdata, 1'b0));
    endtask

    task automatic store_op(input logic [31:0] pc, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [3:0] strb,
                            input logic [31:0] wd, input int delay);
        logic [31:0] inst;
        inst = mk(OP_STORE, f3, 5'd3);
        issue(pc, inst, rd, addr, sd, 1'b1, 1'b0, 1'b1,
              mk_out(pc, inst, 5'd0, addr, 1'b0, 1'b0),
              1'b1, mk_bus(32'h200 & 32'h0 | {addr[31:2], 2'b00}, strb, wd, 1'b1, 1'b1, delay),
              mk_resp(delay, 32'h0, 1'b0));
    endtask

    task automatic misaligned_op(input logic [31:0] pc, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [31:0] addr);
        logic [31:0] inst;
        inst = mk(op, f3, rd);
        issue(pc, inst, rd, addr, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1,
              mk_out(pc, inst, 5'd0, 32'h0, 1'b1, 1'b0),
              1'b0, mk_bus(0, 0, 0, 0, 0, -1), mk_resp(0, 0, 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] inst;
        int          guard;

        RST = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
        A_PC = 32'h0; A_INST = 32'h0; A_VALID = 1'b0; A_REG_D = 5'h0;
        A_REG_D_V = 32'h0; A_STORE_DATA = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_zero("reset_state");
        RST = 1'b1;

        // Plain ALU op: one-cycle pass-through.
        alu_op(32'h1000, mk(OP_IMM, 3'd0, 5'd5), 5'd5, 32'h1111_1111, 5'd5);
        // Loads, back to back, with ACK in REQ cycle 3, 1, 2, 4 (boundary) and 1.
        load_op(32'h1004, 3'b010, 5'd6,  32'h100, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_op(32'h1008, 3'b000, 5'd7,  32'h103, 1, 32'h80FF_00AA, 32'hFFFF_FF80);
        load_op(32'h100C, 3'b100, 5'd8,  32'h103, 2, 32'h80FF_00AA, 32'h0000_0080);
        load_op(32'h1010, 3'b001, 5'd9,  32'h102, 4, 32'h80FF_00AA, 32'hFFFF_80FF);
        load_op(32'h1014, 3'b101, 5'd10, 32'h100, 1, 32'h1234_ABCD, 32'h0000_ABCD);
        // Stores: destination forced to 0, ALU result passes through.
        store_op(32'h1018, 3'b001, 5'd11, 32'h202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 2);
        store_op(32'h101C, 3'b000, 5'd12, 32'h201, 32'h0000_00EE, 4'b0010, 32'hEEEE_EEEE, 1);
        store_op(32'h1020, 3'b010, 5'd0,  32'h300, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1);
        // Misaligned accesses: no request, fault flagged.
        misaligned_op(32'h1024, OP_LOAD,  3'b010, 5'd13, 32'h102);
        misaligned_op(32'h1028, OP_LOAD,  3'b001, 5'd14, 32'h101);
        misaligned_op(32'h102C, OP_STORE, 3'b010, 5'd0,  32'h302);
        // Branch: no register write.
        alu_op(32'h1030, mk(OP_BRANCH, 3'd0, 5'd4), 5'd15, 32'h0000_0001, 5'd0);
        // Flushed instruction produces no output.
        issue(32'h1034, mk(OP_IMM, 3'd0, 5'd16), 5'd16, 32'h77, 32'h0, 1'b1, 1'b1,
              1'b0, mk_out(0, 0, 0, 0, 0, 0),
              1'b0, mk_bus(0, 0, 0, 0, 0, -1), mk_resp(0, 0, 0));

        // Timeout: REQ exactly 4 cycles, then a late ACK while stalled.
        inst = mk(OP_LOAD, 3'b010, 5'd17);
        issue(32'h1038, inst, 5'd17, 32'h400, 32'h0, 1'b1, 1'b0, 1'b1,
              mk_out(32'h1038, inst, 5'd0, 32'h0, 1'b0, 1'b1),
              1'b1, mk_bus(32'h400, 4'b1111, 32'h0, 1'b0, 1'b0, 4),
              mk_resp(0, 32'h0, 1'b1));
        FLUSH = 1'b0;
        wait_idle();
        STALL = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            tests++;
            if (M_VALID !== 1'b1 || M_BUS_ERR !== 1'b1 || M_REG_D_V !== 32'h0 ||
                M_REG_D !== 5'h0 || DMEM_REQ !== 1'b0 || M_PC !== 32'h1038) begin
                fails++;
                $display("FAIL late_ack_hold: got valid=%b err=%b v=%h rd=%0d req=%b pc=%h, required valid=1 err=1 v=0 rd=0 req=0 pc=00001038",
                         M_VALID, M_BUS_ERR, M_REG_D_V, M_REG_D, DMEM_REQ, M_PC);
            end
        end
        STALL = 1'b0;

        // Reset during REQ: request drops, no completion.
        issue(32'h103C, mk(OP_LOAD, 3'b010, 5'd18), 5'd18, 32'h500, 32'h0, 1'b1, 1'b0,
              1'b0, mk_out(0, 0, 0, 0, 0, 0),
              1'b1, mk_bus(32'h500, 4'b1111, 32'h0, 1'b0, 1'b0, 2),
              mk_resp(0, 32'h0, 1'b0));
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_zero("reset_in_req");
        RST = 1'b1;

        // ALU op right after reset.
        alu_op(32'h1040, mk(OP_IMM, 3'd0, 5'd19), 5'd19, 32'h0000_ABCD, 5'd19);
        // Bubble to drain.
        issue(32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0,
              1'b0, mk_out(0, 0, 0, 0, 0, 0),
              1'b0, mk_bus(0, 0, 0, 0, 0, -1), mk_resp(0, 0, 0));

        guard = 0;
        while ((exp_q.size() != 0 || bus_q.size() != 0) && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        repeat (2) @(negedge CLK);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL results_drained: got %0d pending, required 0", exp_q.size());
        end
        tests++;
        if (bus_q.size() != 0) begin
            fails++;
            $display("FAIL requests_drained: got %0d pending, required 0", bus_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
